// File: rtl/wb_arbiter_if.sv
//------------------------------------------------------------------------------
// wb_arbiter_if
// Groups the producer-side result bus and the broadcast bus of wb_arbiter.
// The "slave" modport is the arbiter's view. The "master" modport is the view
// of the functional units and consumers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef TAG_INVALID
`define TAG_INVALID {`INST_TAG_WIDTH{1'b1}}
`endif

interface wb_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]                            src_valid;
  logic [NUM_SRC-1:0]                            src_ready;
  logic [NUM_SRC-1:0][`INST_TAG_WIDTH-1:0]       src_tag;
  logic [NUM_SRC-1:0][4:0]                       src_rd;
  logic [NUM_SRC-1:0][`COMMON_WIDTH-1:0]         src_data;
  logic                                          wb_valid;
  logic [`INST_TAG_WIDTH-1:0]                    wb_tag;
  logic [4:0]                                    wb_rd;
  logic [`COMMON_WIDTH-1:0]                      wb_data;

  modport master (
    output src_valid, src_tag, src_rd, src_data,
    input  src_ready, wb_valid, wb_tag, wb_rd, wb_data
  );

  modport slave (
    input  src_valid, src_tag, src_rd, src_data,
    output src_ready, wb_valid, wb_tag, wb_rd, wb_data
  );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------------------
// wb_arbiter
// Per-source result FIFOs feeding a single registered writeback broadcast.
// Each cycle the arbiter grants one non-empty head in round-robin order.
// Optional macro WB_ARB_PRIO0_EN gives source 0 absolute priority. In that
// mode, round-robin applies only among the remaining sources.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef TAG_INVALID
`define TAG_INVALID {`INST_TAG_WIDTH{1'b1}}
`endif

module wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,      // synchronous, active-low
  input  wire logic     flush,
  wb_arbiter_if.slave   bus
);

  localparam int TW = `INST_TAG_WIDTH;
  localparam int DW = `COMMON_WIDTH;
  localparam int EW = TW + 5 + DW;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NUM_SRC);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef logic [EW-1:0] entry_t;

  logic [NUM_SRC-1:0]          full;
  logic [NUM_SRC-1:0]          nonempty;
  logic [NUM_SRC-1:0]          ready;
  logic [NUM_SRC-1:0][EW-1:0]  head;
  logic                        ready_en;
  logic [SW-1:0]               rr_ptr;
  logic [SW-1:0]               rr_next;
  logic [SW-1:0]               grant;
  logic                        any_req;
  logic                        do_pop;

  // Ready depends only on registered state, so a source never sees a
  // combinational loop through its own valid or the broadcast.
  assign ready         = ready_en ? ~full : '0;
  assign bus.src_ready = ready;
  assign do_pop        = any_req & ~flush;

  // Hold ready low through reset and for the release edge itself.
  always_ff @(posedge clk) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign push        = bus.src_valid[i] & ready[i] & ~flush;
    assign pop         = do_pop & (grant == SW'(i));
    assign full[i]     = (count == CNT_FULL);
    assign nonempty[i] = (count != '0);
    assign head[i]     = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush and reset both empty the queue.
    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end

    // Entry storage; occupancy gates every read, so no reset is needed.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.src_tag[i], bus.src_rd[i], bus.src_data[i]};
    end
  end

  // Round-robin search from rr_ptr with wrap; optional source-0 override.
  always_comb begin
    int            idx;
    logic [SW-1:0] idx_s;
    grant   = '0;
    any_req = 1'b0;
    rr_next = rr_ptr;
    idx     = 0;
    idx_s   = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx   = (int'(rr_ptr) + off) % NUM_SRC;
      idx_s = SW'(idx);
      if (!any_req && nonempty[idx_s]) begin
        any_req = 1'b1;
        grant   = idx_s;
        rr_next = SW'((idx + 1) % NUM_SRC);
      end
    end
`ifdef WB_ARB_PRIO0_EN
    if (nonempty[0]) begin
      any_req = 1'b1;
      grant   = '0;
      rr_next = rr_ptr;
    end
`endif
  end

  // Round-robin pointer advances past each granted source.
  always_ff @(posedge clk) begin
    if (!rst || flush) rr_ptr <= '0;
    else if (do_pop)   rr_ptr <= rr_next;
  end

  // Registered broadcast. With no pop, the outputs drive the idle values:
  // an invalid tag and zero rd and data.
  always_ff @(posedge clk) begin
    if (!rst || !do_pop) begin
      bus.wb_valid <= 1'b0;
      bus.wb_tag   <= `TAG_INVALID;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
    end else begin
      bus.wb_valid <= 1'b1;
      {bus.wb_tag, bus.wb_rd, bus.wb_data} <= head[grant];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. It combines directed scenarios with
// randomized traffic. A queue-based reference model predicts ready and the
// broadcast.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef TAG_INVALID
`define TAG_INVALID {`INST_TAG_WIDTH{1'b1}}
`endif

module tb_wb_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 2;
  localparam int TW      = `INST_TAG_WIDTH;
  localparam int DW      = `COMMON_WIDTH;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  wb_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  wb_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t          q [NUM_SRC][$];
  int            rr;
  bit            rdy_en;
  bit            exp_valid;
  logic [TW-1:0] exp_tag;
  logic [4:0]    exp_rd;
  logic [DW-1:0] exp_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_idle();
    exp_valid = 1'b0;
    exp_tag   = `TAG_INVALID;
    exp_rd    = '0;
    exp_data  = '0;
  endtask

  // One clock edge of the reference model, applied to the inputs present at the edge.
  task automatic model_edge();
    bit   acc [NUM_SRC];
    int   g;
    bit   keep_rr;
    ent_t e;
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) q[i].delete();
      rr = 0; rdy_en = 1'b0; model_idle();
      return;
    end
    if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) q[i].delete();
      rr = 0; rdy_en = 1'b1; model_idle();
      return;
    end
    for (int i = 0; i < NUM_SRC; i++)
      acc[i] = bus.src_valid[i] && rdy_en && (q[i].size() < DEPTH);
    g = -1;
    keep_rr = 1'b0;
`ifdef WB_ARB_PRIO0_EN
    if (q[0].size() > 0) begin g = 0; keep_rr = 1'b1; end
`endif
    if (g < 0) begin
      for (int off = 0; off < NUM_SRC; off++) begin
        int idx;
        idx = (rr + off) % NUM_SRC;
        if (g < 0 && q[idx].size() > 0) g = idx;
      end
    end
    if (g >= 0) begin
      e = q[g].pop_front();
      exp_valid = 1'b1; exp_tag = e.tag; exp_rd = e.rd; exp_data = e.data;
      if (!keep_rr) rr = (g + 1) % NUM_SRC;
    end else begin
      model_idle();
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (acc[i]) begin
        e.tag = bus.src_tag[i]; e.rd = bus.src_rd[i]; e.data = bus.src_data[i];
        q[i].push_back(e);
      end
    end
    rdy_en = 1'b1;
  endtask

  // Check ready before the edge, clock once, then check the broadcast.
  task automatic cycle();
    logic [NUM_SRC-1:0] exp_rdy;
    for (int i = 0; i < NUM_SRC; i++) exp_rdy[i] = rdy_en && (q[i].size() < DEPTH);
    check_val("src_ready", 64'(bus.src_ready), 64'(exp_rdy));
    @(posedge clk);
    model_edge();
    #1;
    check_val("wb_valid", 64'(bus.wb_valid), 64'(exp_valid));
    check_val("wb_tag",   64'(bus.wb_tag),   64'(exp_tag));
    check_val("wb_rd",    64'(bus.wb_rd),    64'(exp_rd));
    check_val("wb_data",  64'(bus.wb_data),  64'(exp_data));
  endtask

  task automatic clear_inputs();
    flush         = 1'b0;
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_rd    = '0;
    bus.src_data  = '0;
  endtask

  task automatic set_src(input int s, input logic [TW-1:0] tag, input logic [4:0] rd,
                         input logic [DW-1:0] data);
    bus.src_valid[s] = 1'b1;
    bus.src_tag[s]   = tag;
    bus.src_rd[s]    = rd;
    bus.src_data[s]  = data;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    rr = 0; rdy_en = 1'b0; model_idle();
    // The first edge brings the DUT out of an unknown state.
    @(posedge clk); model_edge(); #1;
    cycle();                               // ready must be low while reset is held
    rst = 1'b1;
    cycle();                               // release edge
    cycle();                               // idle, ready now all ones

    // Single push from src0: broadcast appears only after the second edge.
    set_src(0, TW'(3), 5'd5, 32'hDEADBEEF);
    cycle();
    clear_inputs();
    cycle();
    check_val("single_valid", 64'(bus.wb_valid), 64'd1);
    check_val("single_data",  64'(bus.wb_data),  64'hDEADBEEF);
    cycle();

    // Writeback to register 0 is passed through unchanged.
    set_src(1, TW'(7), 5'd0, 32'h1234);
    cycle();
    clear_inputs();
    cycle();
    check_val("rd0_tag", 64'(bus.wb_tag), 64'd7);
    check_val("rd0_rd",  64'(bus.wb_rd),  64'd0);
    cycle();

    // Contention: flush first so rr_ptr is 0, then all sources push together.
    flush = 1'b1;
    cycle();
    clear_inputs();
    for (int s = 0; s < NUM_SRC; s++) set_src(s, TW'(10 + s), 5'(s + 1), DW'(100 + s));
    cycle();
    clear_inputs();
    for (int k = 0; k < NUM_SRC; k++) begin
      cycle();
      check_val("contention_tag", 64'(bus.wb_tag), 64'(10 + k));
    end
    cycle();

    // Flush with queued entries and a same-edge push.
    for (int n = 0; n < 2; n++) begin
      set_src(1, TW'(20 + n), 5'd1, DW'(n));
      set_src(3, TW'(30 + n), 5'd3, DW'(n));
      cycle();
    end
    set_src(2, TW'(40), 5'd2, 32'h55);
    flush = 1'b1;
    cycle();
    clear_inputs();
    check_val("flush_valid", 64'(bus.wb_valid), 64'd0);
    check_val("flush_ready", 64'(bus.src_ready), 64'hF);
    for (int n = 0; n < 3; n++) cycle();

    // Randomized traffic with occasional flush and mid-burst reset.
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      flush = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
        bus.src_valid[s] = ($urandom_range(0, 99) < 55);
        bus.src_tag[s]   = TW'($urandom);
        bus.src_rd[s]    = 5'($urandom_range(0, 31));
        bus.src_data[s]  = DW'($urandom);
      end
      cycle();
    end

    // Reset mid-burst, release, then a fresh push must meet the two-edge latency.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    check_val("post_reset_idle", 64'(bus.wb_valid), 64'd0);
    set_src(2, TW'(9), 5'd9, 32'hCAFE);
    cycle();
    clear_inputs();
    cycle();
    check_val("post_reset_tag", 64'(bus.wb_tag), 64'd9);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: NUM_SRC, 4, number of functional-unit result sources (2..8).
REQ-002 Parameter: DEPTH, 2, per-source queue entries (power of 2, >=2).
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous, active-low.
REQ-005 Port: flush  in  1  mispredict/ROB flush; discard all queued results.
REQ-006 Port: src_valid  in  NUM_SRC  per-source result valid.
REQ-007 Port: src_ready  out  NUM_SRC  per-source queue not full.
REQ-008 Port: src_tag  in  NUM_SRC x `INST_TAG_WIDTH  per-source result tag.
REQ-009 Port: src_rd  in  NUM_SRC x 5  per-source destination register.
REQ-010 Port: src_data  in  NUM_SRC x `COMMON_WIDTH  per-source result value.
REQ-011 Port: wb_valid  out  1  broadcast valid this cycle.
REQ-012 Port: wb_tag  out  `INST_TAG_WIDTH  broadcast tag; drives wb_id_inf tag.
REQ-013 Port: wb_rd  out  5  broadcast destination; drives wb_id_inf rd.
REQ-014 Port: wb_data  out  `COMMON_WIDTH  broadcast value; drives wb_id_inf data.

Function
REQ-015 Each source SHALL own a DEPTH-entry FIFO; a push occurs on posedge clk when src_valid[i] && src_ready[i].
REQ-016 src_ready[i] SHALL equal !full[i] from registered occupancy only, with no combinational path from src_valid or wb outputs.
REQ-017 Each cycle, if any FIFO is non-empty and flush is low, exactly one head SHALL be granted and popped.
REQ-018 Grant SHALL be round-robin: search from rr_ptr upward with wrap, then set rr_ptr to (granted index + 1) mod NUM_SRC.
REQ-019 The popped entry SHALL appear on wb_tag/wb_rd/wb_data with wb_valid=1 for exactly one cycle after the pop edge (registered outputs).
REQ-020 Latency: a push into an empty FIFO with no contention at edge k SHALL be broadcast in the cycle following edge k+1.
REQ-021 With no pop, wb_valid SHALL be 0, wb_tag SHALL be `TAG_INVALID, wb_rd 0, wb_data 0, so a consumer comparing tags never matches.
REQ-022 Simultaneous push and pop on the same non-full FIFO SHALL both take effect; occupancy is unchanged.
REQ-023 A FIFO that is full at the edge SHALL accept no push, even if it is popped in the same cycle.
REQ-024 Results with src_rd==0 SHALL be queued and broadcast unchanged; register-0 filtering belongs to the consumer.
REQ-025 Entries from one source SHALL be broadcast in push order; no ordering is guaranteed across sources.
REQ-026 flush high at an edge SHALL empty all FIFOs, drop any same-edge pushes, reset rr_ptr to 0, and force idle wb outputs (REQ-021) for the next cycle.
REQ-027 FIFO read/write pointers SHALL be log2(DEPTH) bits with natural wrap; occupancy SHALL be log2(DEPTH)+1 bits.

Reset
REQ-028 rst low at posedge clk SHALL clear all FIFOs and pointers, set rr_ptr to 0, and drive the idle wb outputs of REQ-021.
REQ-029 While rst is low, src_ready SHALL be 0; one cycle after release it SHALL be all ones.
REQ-030 Reset asserted mid-burst SHALL discard all queued entries, and no stale entry SHALL be broadcast after release.

Configuration
REQ-031 Macro WB_ARB_PRIO0_EN: when defined, source 0 SHALL win whenever its FIFO is non-empty, rr_ptr SHALL be unchanged on a source-0 grant, and round-robin SHALL apply among sources 1..NUM_SRC-1.
REQ-032 Without WB_ARB_PRIO0_EN, all sources SHALL take part equally in round-robin per REQ-018.

Verification
REQ-033 Single push: src0 tag=3, rd=5, data=0xDEADBEEF at edge 1 -> wb_valid=1 with those values only in the cycle after edge 2; idle values before and after.
REQ-034 Contention: sources 0-3 push together at one edge, rr_ptr=0 -> broadcasts in the next 4 cycles in source order 0,1,2,3; with WB_ARB_PRIO0_EN and src0 pushing each cycle, src0 is always granted and 1,2,3 are served only in src0-empty cycles.
REQ-035 Full: src2 pushes 3 consecutive cycles while src0 holds the grant under WB_ARB_PRIO0_EN -> src_ready[2]=0 after 2 accepted pushes, third push rejected, and src2 broadcasts the 2 entries in push order.
REQ-036 Flush: 2 entries queued in each of src1 and src3 plus a same-edge push, flush=1 -> next cycle wb_valid=0, wb_tag=`TAG_INVALID, src_ready all 1; nothing broadcast afterwards.
REQ-037 Reset: rst=0 during a 4-source burst -> idle outputs, src_ready=0 while low; after release no stale broadcast, and a fresh push meets REQ-020 latency.
REQ-038 rd=0: src1 pushes tag=7, rd=0 -> broadcast wb_valid=1, wb_tag=7, wb_rd=0.
